// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow. A start/busy/done
// handshake launches an operation and presents a registered result with borrow and
// zero flags that hold until the next completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    // Full-subtractor cell on the current LSBs and the running borrow.
    logic             a_bit, b_bit, d_bit, br_next;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        a_bit     = a_q[0];
        b_bit     = b_q[0];
        d_bit     = a_bit ^ b_bit ^ br_q;
        br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        // Result fills from the MSB side so the last bit lands at the top.
        res_shift = {d_bit, res_q[WIDTH-1:1]};
    end

    // Next-state and registered-output logic; busy/done reflect the state being entered.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StShift: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                res_d  = res_shift;
                br_d   = br_next;
                cnt_d  = cnt_q + 1'b1;
                busy_d = 1'b1;
                if (cnt_q == LastBit) begin
                    state_d  = StDone;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    diff_d   = res_shift;
                    borrow_d = br_next;
                    zero_d   = (res_shift == '0);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         zero;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] prev_diff;
    logic         prev_bor;
    logic         prev_zero;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eb, input logic ed,
                           input logic [W-1:0] ediff, input logic ebor, input logic ez);
        chk({tag, " busy"}, 32'(busy), 32'(eb));
        chk({tag, " done"}, 32'(done), 32'(ed));
        chk({tag, " diff"}, 32'(diff), 32'(ediff));
        chk({tag, " borrow"}, 32'(borrow_out), 32'(ebor));
        chk({tag, " zero"}, 32'(zero), 32'(ez));
    endtask

    // One operation with a single start pulse. If poke >= 0, a start with a=200, b=1
    // is driven during that SHIFT cycle index and must be ignored.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ediff, input logic ebor, input logic ez,
                          input int poke);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            // Previous result must hold while shifting.
            chk_all({tag, " shift"}, 1'b1, 1'b0, prev_diff, prev_bor, prev_zero);
            if (i == poke) begin
                start = 1'b1;
                a     = 8'd200;
                b     = 8'd1;
            end else if (i == poke + 1) begin
                start = 1'b0;
                a     = 8'd77;
                b     = 8'd66;
            end
            @(negedge clk);
        end
        chk_all({tag, " done"}, 1'b0, 1'b1, ediff, ebor, ez);
        prev_diff = ediff;
        prev_bor  = ebor;
        prev_zero = ez;
        @(negedge clk);
        chk_all({tag, " after"}, 1'b0, 1'b0, ediff, ebor, ez);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        prev_diff = '0;
        prev_bor  = 1'b0;
        prev_zero = 1'b0;

        // Reset held for 3 cycles, then idle with start low.
        repeat (3) begin
            @(negedge clk);
            chk_all("in_reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk_all("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end

        run_op("100-37", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0, -1);
        run_op("37-100", 8'd37, 8'd100, 8'hC1, 1'b1, 1'b0, -1);
        run_op("0-1", 8'd0, 8'd1, 8'hFF, 1'b1, 1'b0, -1);
        run_op("55-55", 8'h55, 8'h55, 8'h00, 1'b0, 1'b1, -1);
        run_op("FF-0", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, -1);

        // Start pulse during the 4th SHIFT cycle is ignored.
        run_op("ignored", 8'd10, 8'd3, 8'd7, 1'b0, 1'b0, 3);
        repeat (20) begin
            @(negedge clk);
            chk_all("no_second", 1'b0, 1'b0, 8'd7, 1'b0, 1'b0);
        end

        // Reset during the 5th SHIFT cycle aborts with no done and a cleared result.
        start = 1'b1;
        a     = 8'd50;
        b     = 8'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort pre busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_all("abort async", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk_all("post_abort", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Start held high: one result every W+2 cycles.
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd4;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("b2b busy", 32'(busy), ((k % 10) < 8) ? 32'd1 : 32'd0);
            chk("b2b done", 32'(done), ((k % 10) == 8) ? 32'd1 : 32'd0);
            if (k >= 8) begin
                chk("b2b diff", 32'(diff), 32'd5);
                chk("b2b borrow", 32'(borrow_out), 32'd0);
                chk("b2b zero", 32'(zero), 32'd0);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
